// File: rtl/gpio_led_engine.sv
// gpio_led_engine: N-channel LED output engine with passthrough, blink, PWM and chaser modes
module gpio_led_engine #(
  parameter int NUM_CH     = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  FAB_CCC_GL0,
  input  logic                  FAB_RESET,
  input  logic [NUM_CH-1:0]     GPIO_M2F,
  input  logic                  CFG_WE,
  input  logic [1:0]            CFG_MODE,
  input  logic [PWM_BITS-1:0]   CFG_DUTY,
  input  logic [PRESCALE_W-1:0] CFG_PRESCALE,
  output logic [NUM_CH-1:0]     LED,
  output logic                  TICK,
  output logic                  FRAME
);
  localparam int POS_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [1:0]            mode_q, mode_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d, wcnt_q, wcnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  phase_q, phase_d, tick_q, frame_q;
  logic [NUM_CH-1:0]     led_q, led_d;
  logic                  tick_i, frame_i;
  always_comb begin
    tick_i     = pcnt_q == prescale_q;
    frame_i    = tick_i && (&wcnt_q);
    mode_d     = CFG_WE ? CFG_MODE : mode_q;
    duty_d     = CFG_WE ? CFG_DUTY : duty_q;
    prescale_d = CFG_WE ? CFG_PRESCALE : prescale_q;
    // a config write restarts every counter and swallows a coincident tick
    pcnt_d     = (CFG_WE || tick_i) ? '0 : pcnt_q + PRESCALE_W'(1);
    wcnt_d     = CFG_WE ? '0 : wcnt_q + PWM_BITS'(tick_i);
    phase_d    = CFG_WE ? 1'b0 : phase_q ^ frame_i;
    pos_d      = CFG_WE ? '0 :
                 !frame_i ? pos_q :
                 (pos_q == POS_W'(NUM_CH - 1)) ? '0 : pos_q + POS_W'(1);
    led_d      = mode_q == 2'd0 ? GPIO_M2F :
                 mode_q == 2'd1 ? GPIO_M2F & {NUM_CH{phase_q}} :
                 mode_q == 2'd2 ? GPIO_M2F & {NUM_CH{wcnt_q < duty_q}} :
                                  GPIO_M2F & (NUM_CH'(1) << pos_q);
  end
  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      mode_q     <= '0;
      duty_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      wcnt_q     <= '0;
      pos_q      <= '0;
      phase_q    <= 1'b0;
      led_q      <= '0;
      tick_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      wcnt_q     <= wcnt_d;
      pos_q      <= pos_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
      tick_q     <= tick_i && !CFG_WE;
      frame_q    <= frame_i && !CFG_WE;
    end
  end
  assign LED   = led_q;
  assign TICK  = tick_q;
  assign FRAME = frame_q;
endmodule

// File: doc/gpio_led_engine.md
# gpio_led_engine

Parametrised fabric LED/GPIO output engine. It generalises the fixed 8-bit MSS-to-fabric GPIO passthrough into N channels with four selectable output modes: passthrough, blink, PWM dimming and chaser. It sits between the MSS GPIO_x_M2F outputs and the board LED pins, clocked from the fabric CCC. The MSS GPIO bits serve as passthrough data or as a per-channel enable mask.

## Interface
- NUM_CH, 8: number of output channels (1..32).
- PWM_BITS, 8: PWM counter/duty width; one frame = 2^PWM_BITS ticks.
- PRESCALE_W, 16: prescaler width.

- FAB_CCC_GL0  in  1  fabric clock.
- FAB_RESET  in  1  synchronous, active-high reset.
- GPIO_M2F  in  NUM_CH  MSS GPIO bits; passthrough data (mode 0) or channel mask (modes 1-3).
- CFG_WE  in  1  one-cycle config load strobe.
- CFG_MODE  in  2  0 passthrough, 1 blink, 2 PWM, 3 chaser.
- CFG_DUTY  in  PWM_BITS  PWM duty.
- CFG_PRESCALE  in  PRESCALE_W  tick period minus one.
- LED  out  NUM_CH  registered channel outputs.
- TICK  out  1  registered prescaler pulse.
- FRAME  out  1  registered frame-wrap pulse.

## Operation
- Config registers mode, duty and prescale are loaded on CFG_WE. They are held otherwise.
- Prescaler counter pcnt runs 0..prescale.
  - When pcnt == prescale, tick_i = 1 and pcnt returns to 0.
  - prescale = 0 gives a tick every cycle.
- PWM counter wcnt (PWM_BITS) increments on tick_i and wraps from all-ones to 0.
  - frame_i = tick_i and wcnt == all-ones.
- Phase bit toggles on frame_i.
- Chaser position pos (0..NUM_CH-1) increments on frame_i and wraps from NUM_CH-1 to 0.
- LED next-state per mode:
  - 0: LED = GPIO_M2F.
  - 1: LED = GPIO_M2F & {NUM_CH{phase}}.
  - 2: LED = GPIO_M2F & {NUM_CH{wcnt < duty}}.
  - 3: LED = GPIO_M2F & onehot(pos).
- PWM edge cases:
  - duty = 0 gives constant off.
  - duty = all-ones gives on for 2^PWM_BITS-1 of every 2^PWM_BITS ticks.
  - The compare is unsigned.
- Chaser: a masked-off position stays dark but still consumes its frame. Positions are never skipped.
- CFG_WE also clears pcnt, wcnt, phase and pos. It takes priority over a tick/frame in the same cycle, so that tick is lost and no counter advances.
- GPIO_M2F changes take effect on the next LED update without resetting any counter.

## Timing
- Reset (FAB_RESET high at a clock edge):
  - LED = 0, TICK = 0, FRAME = 0.
  - mode = 0, duty = 0, prescale = 0.
  - pcnt = wcnt = pos = 0, phase = 0.
- Reset mid-operation behaves identically. In the first cycle after deassertion, outputs follow mode 0.
- LED is registered from the current state.
  - Mode 0 latency: GPIO_M2F to LED is one cycle.
  - Modes 1-3: LED reflects counter state one cycle after the counter updates.
- TICK and FRAME are registered copies of tick_i and frame_i, so they lag the internal pulses by one cycle. Each is high for exactly one cycle.
- Config applies in the cycle after CFG_WE. Counters restart from 0 that cycle, and the first tick occurs prescale+1 cycles later.
- Periods with prescale P:
  - tick every P+1 cycles.
  - frame every (P+1)·2^PWM_BITS cycles.
  - blink full period 2·(P+1)·2^PWM_BITS cycles.
  - chaser revisit NUM_CH·(P+1)·2^PWM_BITS cycles.

## Test plan
- Reset: drive GPIO_M2F = 0xFF, pulse FAB_RESET for 2 cycles -> LED = 0x00, TICK = FRAME = 0. Next cycle LED = 0xFF (mode 0).
- Passthrough: mode 0, GPIO_M2F steps 0x00 -> 0xA5 -> LED = 0xA5 exactly one cycle later. TICK pulses every cycle (prescale 0).
- PWM: NUM_CH=8, PWM_BITS=8, mode 2, duty 64, prescale 0, mask 0x0F -> LED = 0x0F for 64 cycles then 0x00 for 192, repeating. FRAME every 256 cycles. Duty 0 -> LED stays 0x00.
- Blink: mode 1, prescale 1, mask 0x81 -> LED alternates 0x00 / 0x81 every 512 cycles.
- Chaser: mode 3, prescale 0, mask 0xFF -> LED = 0x01, 0x02, ... 0x80, then wraps to 0x01. Each step lasts 256 cycles. With mask 0xF0, LED stays 0x00 for the first 4 frames.
- Reconfig collision: assert CFG_WE (mode 3) in the same cycle as FRAME-generating tick_i -> pos = 0, no advance, LED = 0x01 for a full 256-cycle frame. Assert FAB_RESET mid-chase -> LED = 0x00, then mode 0.
